dualport_ram_mbox: RTL

- Parametrised true dual-port RAM with mailbox doorbells; successor to the fixed 256x16 shared RAM between the J1 core (port 1) and the peripheral core (port 2).
- Adds configurable width/depth, byte-enable writes, read-valid strobes, cross-port collision detection, and a doorbell interrupt per port.
- One doorbell fires when the opposite port writes a designated mailbox word.
- All state updates on negedge clk, keeping existing J1 posedge-sampling timing.

---
 rtl/dualport_ram_mbox_pkg.sv | 19 +
 rtl/dualport_ram_mbox_if.sv | 25 ++
 rtl/dualport_ram_mbox_flag.sv | 31 +++
 rtl/dualport_ram_mbox.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/dualport_ram_mbox_pkg.sv
// Shared constants and helpers for the dual-port mailbox RAM.
package dpram_pkg;

    localparam int unsigned DefDataW = 16;
    localparam int unsigned DefAddrW = 8;

    typedef enum logic {
        ReadFirst,
        WriteFirst
    } rw_policy_e;

    // A read colliding with a write on the other port returns the pre-write word.
    localparam rw_policy_e RwPolicy = ReadFirst;

    function automatic int unsigned lane_count(input int unsigned data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/dualport_ram_mbox_if.sv
// One RAM port: request/write-data towards the RAM, read data and doorbell back.
interface dualport_ram_mbox_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 8
);
    logic [DATA_W-1:0]   d_in;
    logic [DATA_W/8-1:0] be;
    logic [ADDR_W-1:0]   addr;
    logic                rd;
    logic                wr;
    logic                irq_ack;
    logic [DATA_W-1:0]   d_out;
    logic                rvalid;
    logic                irq;

    modport master (
        output d_in, be, addr, rd, wr, irq_ack,
        input  d_out, rvalid, irq
    );

    modport slave (
        input  d_in, be, addr, rd, wr, irq_ack,
        output d_out, rvalid, irq
    );
endinterface

// File: rtl/dualport_ram_mbox_flag.sv
// Doorbell flag: set has priority over clear, async active-high reset, falling-edge state.
module dpram_mbox_flag (
    input  logic clk,
    input  logic rst,
    input  logic set_i,
    input  logic clr_i,
    output logic flag_o
);
    logic flag_d, flag_q;

    // Next state: set wins over a simultaneous clear.
    always_comb begin
        flag_d = flag_q;
        if (set_i) begin
            flag_d = 1'b1;
        end else if (clr_i) begin
            flag_d = 1'b0;
        end
    end

    // Flag register.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            flag_q <= 1'b0;
        end else begin
            flag_q <= flag_d;
        end
    end

    assign flag_o = flag_q;
endmodule

// File: rtl/dualport_ram_mbox.sv
// True dual-port RAM with byte enables, collision flag and per-port mailbox doorbells.
// All state changes on the falling clock edge. Optional macro DPRAM_OUTREG_EN adds an
// output register stage (read latency 2 edges).
module dualport_ram_mbox
    import dpram_pkg::*;
#(
    parameter int unsigned DATA_W      = DefDataW,
    parameter int unsigned ADDR_W      = DefAddrW,
    parameter int unsigned MBOX_ADDR_1 = 2**ADDR_W - 1,
    parameter int unsigned MBOX_ADDR_2 = 2**ADDR_W - 2
) (
    input  logic                clk,
    input  logic                rst,
    dualport_ram_mbox_if.slave  p1,
    dualport_ram_mbox_if.slave  p2,
    output logic                coll_o
);
    localparam int unsigned Lanes = lane_count(DATA_W);
    localparam int unsigned Depth = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] Mbox1 = ADDR_W'(MBOX_ADDR_1);
    localparam logic [ADDR_W-1:0] Mbox2 = ADDR_W'(MBOX_ADDR_2);

    logic [DATA_W-1:0] mem_q [Depth];

    // Index 0 is port 1, index 1 is port 2.
    logic [DATA_W-1:0] d_in   [2];
    logic [Lanes-1:0]  be     [2];
    logic [ADDR_W-1:0] addr   [2];
    logic              rd     [2];
    logic              wr_eff [2];

    assign d_in[0] = p1.d_in;
    assign d_in[1] = p2.d_in;
    assign be[0]   = p1.be;
    assign be[1]   = p2.be;
    assign addr[0] = p1.addr;
    assign addr[1] = p2.addr;
    assign rd[0]   = p1.rd;
    assign rd[1]   = p2.rd;
    // Read beats write on the same port; an all-zero byte mask is not a write at all.
    assign wr_eff[0] = p1.wr & ~p1.rd & (|p1.be);
    assign wr_eff[1] = p2.wr & ~p2.rd & (|p2.be);

    // RAM write: port 2 lanes first so port 1 lanes overwrite them on a same-address clash.
    always_ff @(negedge clk) begin
        for (int unsigned i = 0; i < Lanes; i++) begin
            if (wr_eff[1] && be[1][i]) begin
                mem_q[addr[1]][i*8 +: 8] <= d_in[1][i*8 +: 8];
            end
        end
        for (int unsigned i = 0; i < Lanes; i++) begin
            if (wr_eff[0] && be[0][i]) begin
                mem_q[addr[0]][i*8 +: 8] <= d_in[0][i*8 +: 8];
            end
        end
    end

    logic [DATA_W-1:0] rdata_d  [2];
    logic [DATA_W-1:0] rdata_q  [2];
    logic              rvalid_d [2];
    logic              rvalid_q [2];

    // Read stage next state: reads sample the pre-edge array contents (read-first).
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rvalid_d[p] = rd[p];
            rdata_d[p]  = rd[p] ? mem_q[addr[p]] : rdata_q[p];
        end
    end

    // Read stage registers.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            rdata_q  <= '{default: '0};
            rvalid_q <= '{default: 1'b0};
        end else begin
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
        end
    end

`ifdef DPRAM_OUTREG_EN
    logic [DATA_W-1:0] out_data_d  [2];
    logic [DATA_W-1:0] out_data_q  [2];
    logic              out_valid_q [2];

    // Output stage loads only when the read stage holds fresh data.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            out_data_d[p] = rvalid_q[p] ? rdata_q[p] : out_data_q[p];
        end
    end

    // Output stage registers.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            out_data_q  <= '{default: '0};
            out_valid_q <= '{default: 1'b0};
        end else begin
            out_data_q  <= out_data_d;
            out_valid_q <= rvalid_q;
        end
    end

    assign p1.d_out  = out_data_q[0];
    assign p2.d_out  = out_data_q[1];
    assign p1.rvalid = out_valid_q[0];
    assign p2.rvalid = out_valid_q[1];
`else
    assign p1.d_out  = rdata_q[0];
    assign p2.d_out  = rdata_q[1];
    assign p1.rvalid = rvalid_q[0];
    assign p2.rvalid = rvalid_q[1];
`endif

    logic coll_d, coll_q;

    // Collision is sticky until reset.
    always_comb begin
        coll_d = coll_q | (wr_eff[0] & wr_eff[1] & (addr[0] == addr[1]));
    end

    // Collision flag register.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            coll_q <= 1'b0;
        end else begin
            coll_q <= coll_d;
        end
    end

    assign coll_o = coll_q;

    // Port 2 doorbell: rung by port 1 writing Mbox1, cleared by ack or port 2 reading it.
    dpram_mbox_flag u_irq_2 (
        .clk    (clk),
        .rst    (rst),
        .set_i  (wr_eff[0] && (addr[0] == Mbox1)),
        .clr_i  (p2.irq_ack || (rd[1] && (addr[1] == Mbox1))),
        .flag_o (p2.irq)
    );

    // Port 1 doorbell: rung by port 2 writing Mbox2, cleared by ack or port 1 reading it.
    dpram_mbox_flag u_irq_1 (
        .clk    (clk),
        .rst    (rst),
        .set_i  (wr_eff[1] && (addr[1] == Mbox2)),
        .clr_i  (p1.irq_ack || (rd[0] && (addr[0] == Mbox2))),
        .flag_o (p1.irq)
    );
endmodule
